universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised WIDTH-bit register: hold, parallel load, shift, rotate, clear, and an
//  auto-sequenced serial frame transmit (load, then shift out LSB-first for WIDTH cycles).
//  Generalises single-bit D storage into a multi-mode word register with enable and status.
//  Sits between parallel datapath logic and serial links / bit-serial consumers.
// PARAMETERS
//  WIDTH      8    data width in bits, >= 2
//  RESET_VAL  0    value of q after reset (WIDTH bits)
//  CW         $clog2(WIDTH+1)  bit-counter width (localparam, not overridable)
// PORTS
//  clk     in   1      clock; all state changes on rising edge
//  reset   in   1      synchronous, active-high reset
//  en      in   1      clock enable; 0 = freeze all state incl. frame progress
//  mode    in   3      operation select (see BEHAVIOUR)
//  d       in   WIDTH  parallel load data
//  sin_l   in   1      serial in, enters bit 0 on shift-left
//  sin_r   in   1      serial in, enters bit WIDTH-1 on shift-right / frame
//  q       out  WIDTH  register contents
//  sout    out  1      serial out = q[0] (combinational from q)
//  busy    out  1      high while a frame is in progress
//  done    out  1      one-cycle pulse on the edge completing a frame
//  cnt     out  CW     bits remaining in current frame
// BEHAVIOUR
//  Reset (reset=1 at rising edge, overrides en/mode): q=RESET_VAL, busy=0, done=0, cnt=0.
//  en=0: q, busy, cnt hold; done forced 0. All modes take effect at the next edge (1-cycle latency).
//  Idle (busy=0, en=1) modes:
//   000 HOLD : q unchanged
//   001 LOAD : q <= d
//   010 SHL  : q <= {q[WIDTH-2:0], sin_l}
//   011 SHR  : q <= {sin_r, q[WIDTH-1:1]}
//   100 ROTL : q <= {q[WIDTH-2:0], q[WIDTH-1]}
//   101 ROTR : q <= {q[0], q[WIDTH-1:1]}
//   110 FRAME: q <= d, busy <= 1, cnt <= WIDTH
//   111 CLR  : q <= 0 (not RESET_VAL)
//  States: IDLE, SHIFTING (busy=1).
//  SHIFTING, en=1: mode ignored; q <= {sin_r, q[WIDTH-1:1]}, cnt <= cnt-1.
//   Edge where cnt==1: final shift, cnt<=0, busy<=0, done<=1 -> back to IDLE.
//   sout therefore presents d[0..WIDTH-1] on WIDTH consecutive enabled cycles after FRAME edge.
//  SHIFTING, en=0: pause; q, cnt held; frame resumes when en returns.
//  done: high exactly one cycle after completing edge; never high while busy=1.
//  FRAME requested in the cycle busy falls is accepted at the next edge (back-to-back frames,
//   no gap cycle needed beyond the IDLE cycle in which mode is sampled).
//  Reset mid-frame: frame aborted, outputs to reset values, no done pulse.
//  cnt is 0 whenever busy=0. No overflow: cnt only loaded with WIDTH, only decremented while >0.
// TESTING
//  1 reset=1 one edge, WIDTH=8, RESET_VAL=8'hA5 -> q=A5, busy=0, done=0, cnt=0.
//  2 LOAD d=8'h81; SHL sin_l=0 x1 -> q=02; ROTR x1 -> q=01; ROTL x2 -> q=04; CLR -> q=00.
//  3 FRAME d=8'hC3, sin_r=0, en=1 -> sout sequence 1,1,0,0,0,0,1,1 over 8 edges; busy high 8
//    cycles; done pulses once; final q=00; mode toggling during frame has no effect.
//  4 FRAME d=8'h0F, drop en for 3 cycles after 2nd shift -> q, cnt (6) frozen; frame completes
//    3 cycles late; done still a single pulse.
//  5 FRAME d=8'hFF, assert reset after 4th shift -> q=RESET_VAL, busy=0, cnt=0, no done pulse.
//  6 Two FRAMEs d=8'h55 then 8'hAA with mode=FRAME held -> second starts the edge after
//    busy=0 is sampled; sout stream 1010_1010 then 0101_0101; two done pulses.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal WIDTH-bit shift register: hold, load, shift, rotate, clear,
// plus an auto-sequenced LSB-first serial frame transmitter.
module universal_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CW        = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cnt
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_FRAME = 3'b110;
  localparam logic [2:0] M_CLR   = 3'b111;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] SHIFTING = 1'b1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (en) begin
      if (state_q == SHIFTING) begin
        // Frame bits leave through q[0]; mode is ignored mid-frame
        q_d   = {sin_r, q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        unique case (mode)
          M_HOLD:  q_d = q_q;
          M_LOAD:  q_d = d;
          M_SHL:   q_d = {q_q[WIDTH-2:0], sin_l};
          M_SHR:   q_d = {sin_r, q_q[WIDTH-1:1]};
          M_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          M_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
          M_FRAME: begin
            q_d     = d;
            state_d = SHIFTING;
            cnt_d   = CW'(WIDTH);
          end
          M_CLR:   q_d = '0;
          default: q_d = q_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= RESET_VAL;
      state_q <= IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q    = q_q;
  assign sout = q_q[0];
  assign busy = (state_q == SHIFTING);
  assign done = done_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed and randomized checks of universal_shift_reg against an
// arithmetic reference model (WIDTH=8, RESET_VAL=8'hA5).
module tb_universal_shift_reg;

  localparam int W    = 8;
  localparam int MOD  = 256;
  localparam int HALF = 128;
  localparam int RV   = 'hA5;

  logic         clk;
  logic         reset;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] q;
  logic         sout;
  logic         busy;
  logic         done;
  logic [3:0]   cnt;

  int tests = 0;
  int fails = 0;
  int done_cnt;

  int m_q;
  int m_cnt;
  bit m_busy;
  bit m_done;

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout(sout),
    .busy(busy), .done(done), .cnt(cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: word treated as an integer 0..255, shifts as *2 and /2
  task automatic model(bit r, bit e, int md, int dv, bit sl, bit sr);
    if (r) begin
      m_q = RV; m_busy = 0; m_cnt = 0; m_done = 0;
    end else if (!e) begin
      m_done = 0;
    end else if (m_busy) begin
      m_q    = m_q / 2 + sr * HALF;
      m_cnt  = m_cnt - 1;
      m_busy = (m_cnt != 0);
      m_done = (m_cnt == 0);
    end else begin
      m_done = 0;
      case (md)
        1: m_q = dv;
        2: m_q = (m_q * 2 + sl) % MOD;
        3: m_q = m_q / 2 + sr * HALF;
        4: m_q = (m_q * 2) % MOD + m_q / HALF;
        5: m_q = m_q / 2 + (m_q % 2) * HALF;
        6: begin m_q = dv; m_busy = 1; m_cnt = W; end
        7: m_q = 0;
        default: ;
      endcase
    end
  endtask

  task automatic step(string tag, bit r, bit e, int md, int dv,
                      bit sl, bit sr);
    reset = r; en = e; mode = 3'(md); d = 8'(dv);
    sin_l = sl; sin_r = sr;
    model(r, e, md, dv, sl, sr);
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
    chk({tag, ".q"},    32'(q),    32'(m_q));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
    chk({tag, ".sout"}, 32'(sout), 32'(m_q % 2));
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b0; en = 1'b0; mode = '0; d = '0;
    sin_l = 1'b0; sin_r = 1'b0;
    m_q = 0; m_cnt = 0; m_busy = 0; m_done = 0;
    done_cnt = 0;
    @(negedge clk);

    // reset state
    step("rst", 1, 1, 6, 'h3C, 0, 0);
    chk("rst_q", 32'(q), 32'hA5);

    // basic modes
    step("load", 0, 1, 1, 'h81, 0, 0);
    step("shl",  0, 1, 2, 0, 0, 0);
    chk("shl_q", 32'(q), 32'h02);
    step("rotr", 0, 1, 5, 0, 0, 0);
    chk("rotr_q", 32'(q), 32'h01);
    step("rotl", 0, 1, 4, 0, 0, 0);
    step("rotl", 0, 1, 4, 0, 0, 0);
    chk("rotl_q", 32'(q), 32'h04);
    step("clr",  0, 1, 7, 0, 0, 0);
    chk("clr_q", 32'(q), 32'h00);

    // frame C3 with mode toggling
    done_cnt = 0;
    v = 8'hC3;
    step("f3", 0, 1, 6, 'hC3, 0, 0);
    chk("f3_sout0", 32'(sout), 32'(v[0]));
    for (int i = 1; i <= 8; i++) begin
      step("f3", 0, 1, $urandom_range(0, 7), $urandom, $urandom, 0);
      if (i < 8) chk("f3_sout", 32'(sout), 32'(v[i]));
    end
    chk("f3_q", 32'(q), 32'h00);
    chk("f3_done_cnt", 32'(done_cnt), 32'd1);
    step("f3_post", 0, 1, 0, 0, 0, 0);

    // frame 0F with 3-cycle pause after 2nd shift
    done_cnt = 0;
    step("f4", 0, 1, 6, 'h0F, 0, 0);
    step("f4", 0, 1, 0, 0, 0, 1);
    step("f4", 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("f4_pause", 0, 0, 6, 'hFF, 1, 1);
      chk("f4_cnt_frozen", 32'(cnt), 32'd6);
    end
    for (int i = 0; i < 6; i++) step("f4", 0, 1, 3, 0, 0, 0);
    chk("f4_busy_end", 32'(busy), 32'd0);
    chk("f4_done_cnt", 32'(done_cnt), 32'd1);
    step("f4_post", 0, 1, 0, 0, 0, 0);

    // frame FF aborted by reset after 4th shift
    done_cnt = 0;
    step("f5", 0, 1, 6, 'hFF, 0, 0);
    for (int i = 0; i < 4; i++) step("f5", 0, 1, 0, 0, 0, 0);
    step("f5_rst", 1, 1, 0, 0, 0, 0);
    step("f5_post", 0, 1, 0, 0, 0, 0);
    step("f5_post", 0, 1, 0, 0, 0, 0);
    chk("f5_done_cnt", 32'(done_cnt), 32'd0);

    // back-to-back frames 55 then AA, mode FRAME held
    done_cnt = 0;
    v = 8'h55;
    step("f6a", 0, 1, 6, 'h55, 0, 0);
    chk("f6a_sout", 32'(sout), 32'(v[0]));
    for (int i = 1; i <= 8; i++) begin
      step("f6a", 0, 1, 6, 'hAA, 0, 0);
      if (i < 8) chk("f6a_sout", 32'(sout), 32'(v[i]));
    end
    v = 8'hAA;
    step("f6b", 0, 1, 6, 'hAA, 0, 0);
    chk("f6b_busy", 32'(busy), 32'd1);
    chk("f6b_sout", 32'(sout), 32'(v[0]));
    for (int i = 1; i <= 8; i++) begin
      step("f6b", 0, 1, 0, 0, 0, 0);
      if (i < 8) chk("f6b_sout", 32'(sout), 32'(v[i]));
    end
    chk("f6_done_cnt", 32'(done_cnt), 32'd2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 47) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
           $urandom_range(0, 255), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
